wsm_mul: RTL and testbench

- Word-serial integer multiplier sitting directly upstream of the word-level Montgomery reducer (wlm).
- Accepts operands A, B (LOGQ bits each) plus the modulus high part qH via a valid/ready handshake.
- Produces the full 2*LOGQ-bit product C, with qH time-aligned to it, as a one-cycle valid pulse. The reducer's C/qH inputs consume this.
- Processes B one DW-bit digit per cycle, trading area for throughput.

---
 rtl/wsm_mul_pkg.sv | 15 +
 rtl/wsm_pp.sv | 14 +
 rtl/wsm_mul.sv | 103 ++++++++++
 tb/tb_wsm_mul.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/wsm_mul_pkg.sv
// Shared definitions for the word-serial multiplier: FSM state type and
// the latency helpers used by the integrator for valid tracking.
package wsm_mul_pkg;

  typedef enum logic {IDLE, BUSY} wsm_state_t;

  function automatic int wsm_ndig(input int logq, input int dw);
    return (logq + dw - 1) / dw;
  endfunction

  function automatic int wsm_lat(input int logq, input int dw);
    return wsm_ndig(logq, dw);
  endfunction

endpackage

// File: rtl/wsm_pp.sv
// Combinational LOGQ x DW digit multiplier, kept separate so DSP mapping
// and retiming can be tuned on their own.
module wsm_pp #(
  parameter int LOGQ = 60,
  parameter int DW   = 20
) (
  input  logic [LOGQ-1:0]    a,
  input  logic [DW-1:0]      d,
  output logic [LOGQ+DW-1:0] p
);

  assign p = (LOGQ+DW)'(a) * (LOGQ+DW)'(d);

endmodule

// File: rtl/wsm_mul.sv
// Word-serial integer multiplier: one DW-bit digit of B per cycle, full
// 2*LOGQ-bit product delivered with its qH as a one-cycle valid pulse.
module wsm_mul
  import wsm_mul_pkg::*;
#(
  parameter int LOGQ = 60,
  parameter int W    = 17,
  parameter int DW   = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LOGQ-1:0]       A,
  input  logic [LOGQ-1:0]       B,
  input  logic [LOGQ-W-1:0]     qH_in,
  output logic                  out_valid,
  output logic [2*LOGQ-1:0]     C,
  output logic [LOGQ-W-1:0]     qH
);

  localparam int LOGQH = LOGQ - W;
  localparam int K     = 2 * LOGQ;
  localparam int NDIG  = wsm_ndig(LOGQ, DW);
  localparam int BW    = NDIG * DW;
  localparam int CW    = (NDIG > 1) ? $clog2(NDIG) : 1;

  wsm_state_t             state, state_d;
  logic [CW-1:0]          cnt;
  logic [K-1:0]           acc, pp_ext, acc_next;
  logic [LOGQ-1:0]        a_r;
  logic [BW-1:0]          b_r, b_pad;
  logic [LOGQH-1:0]       qh_r;
  logic [LOGQ+DW-1:0]     pp;
  logic                   last, accept;

  wsm_pp #(.LOGQ(LOGQ), .DW(DW)) u_pp (
    .a (a_r),
    .d (b_r[DW-1:0]),
    .p (pp)
  );

  always_comb begin
    b_pad            = '0;
    b_pad[LOGQ-1:0]  = B;
    pp_ext           = '0;
    pp_ext[LOGQ+DW-1:0] = pp;
    acc_next         = acc + (pp_ext << (int'(cnt) * DW));
    last             = (cnt == CW'(NDIG - 1));
    accept           = (state == IDLE) && in_valid;
    in_ready         = (state == IDLE) && !rst;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (in_valid) state_d = BUSY;
      BUSY: if (last)     state_d = IDLE;
      default:            state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // B is shifted down one digit per cycle so the multiplier always sees the
  // low digit; cnt only sets the weight of the partial product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      acc       <= '0;
      a_r       <= '0;
      b_r       <= '0;
      qh_r      <= '0;
      out_valid <= 1'b0;
      C         <= '0;
      qH        <= '0;
    end else begin
      out_valid <= 1'b0;
      if (accept) begin
        a_r  <= A;
        b_r  <= b_pad;
        qh_r <= qH_in;
        acc  <= '0;
        cnt  <= '0;
      end else if (state == BUSY) begin
        acc <= acc_next;
        b_r <= b_r >> DW;
        if (last) begin
          cnt       <= '0;
          C         <= acc_next;
          qH        <= qh_r;
          out_valid <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_wsm_mul.sv
// Self-checking bench for wsm_mul: a DW=20 (3-digit) and a DW=60
// (single-digit) instance checked against a plain wide-multiply model.
module tb_wsm_mul;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         iv [2];
  logic         ir [2];
  logic [59:0]  a  [2];
  logic [59:0]  b  [2];
  logic [42:0]  qi [2];
  logic         ov [2];
  logic [119:0] c  [2];
  logic [42:0]  qo [2];

  wsm_mul #(.LOGQ(60), .W(17), .DW(20)) dut (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
    .A(a[0]), .B(b[0]), .qH_in(qi[0]),
    .out_valid(ov[0]), .C(c[0]), .qH(qo[0])
  );

  wsm_mul #(.LOGQ(60), .W(17), .DW(60)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
    .A(a[1]), .B(b[1]), .qH_in(qi[1]),
    .out_valid(ov[1]), .C(c[1]), .qH(qo[1])
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [119:0] ref_mul(input logic [59:0] x, input logic [59:0] y);
    logic [119:0] xx, yy;
    xx = {60'd0, x};
    yy = {60'd0, y};
    return xx * yy;
  endfunction

  function automatic logic [59:0] rnd60();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[59:0];
  endfunction

  typedef struct {
    logic [59:0]  a;
    logic [59:0]  b;
    logic [42:0]  q;
    logic [119:0] c;
  } vec_t;

  vec_t tbl [12];

  // Called at a negedge; waits for ready, issues one bundle, checks result.
  task automatic run_op(input int s, input logic [59:0] x, input logic [59:0] y,
                        input logic [42:0] q, input logic [119:0] expc,
                        input int exp_lat, input string tag);
    int t;
    int lat;
    logic [119:0] held;
    t = 0;
    while (!ir[s] && t < 50) begin @(negedge clk); t++; end
    if (!ir[s]) begin check({tag, " ready timeout"}, 0, 1); return; end
    iv[s] = 1'b1; a[s] = x; b[s] = y; qi[s] = q;
    @(posedge clk);
    @(negedge clk);
    iv[s] = 1'b0; a[s] = rnd60(); b[s] = rnd60(); qi[s] = 43'(rnd60());
    lat = 0;
    while (!ov[s] && lat < 50) begin @(negedge clk); lat++; end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " C"}, c[s], expc);
    check({tag, " qH"}, qo[s], q);
    held = c[s];
    @(negedge clk);
    check({tag, " pulse end"}, ov[s], 0);
    check({tag, " C hold"}, c[s], held);
  endtask

  // Holds in_valid high, offering bundle 0 then bundle 1 once 0 is taken.
  task automatic run_two(input int s, input logic [59:0] a0, input logic [59:0] b0,
                         input logic [59:0] a1, input logic [59:0] b1,
                         output int acc0, output int acc1, output int pul0, output int pul1,
                         output logic [119:0] pc0, output logic [119:0] pc1,
                         output int nacc, output int npul, output logic stable);
    logic took;
    acc0 = -1; acc1 = -1; pul0 = -1; pul1 = -1; pc0 = '0; pc1 = '0;
    nacc = 0; npul = 0; stable = 1'b1;
    iv[s] = 1'b1; a[s] = a0; b[s] = b0;
    for (int e = 0; e < 12; e++) begin
      took = ir[s] && iv[s];
      @(posedge clk);
      @(negedge clk);
      if (took) begin
        if (nacc == 0) begin acc0 = e; a[s] = a1; b[s] = b1; end
        else begin acc1 = e; iv[s] = 1'b0; end
        nacc++;
      end
      if (ov[s]) begin
        if (npul == 0) begin pul0 = e; pc0 = c[s]; end
        else if (npul == 1) begin pul1 = e; pc1 = c[s]; end
        npul++;
      end else if (npul == 1 && c[s] !== pc0) begin
        stable = 1'b0;
      end
    end
  endtask

  initial begin
    int acc0, acc1, pul0, pul1, nacc, npul, seen;
    logic [119:0] pc0, pc1;
    logic stable;

    tbl[0] = '{60'd3, 60'd5, 43'h1234, 120'd15};
    tbl[1] = '{60'hFFF_FFFF_FFFF_FFFF, 60'hFFF_FFFF_FFFF_FFFF, 43'h7FF,
               120'hFFFFFFFFFFFFFFE000000000000001};
    tbl[2] = '{60'd0, 60'hFFF_FFFF_FFFF_FFFF, 43'h1, 120'd0};
    tbl[3] = '{60'hFFF_FFFF_FFFF_FFFF, 60'd1, 43'h2, 120'hFFF_FFFF_FFFF_FFFF};
    tbl[4] = '{60'd1, 60'h100_0000_0000, 43'h3, 120'h100_0000_0000};
    tbl[5] = '{60'h800_0000_0000_0000, 60'h800_0000_0000_0000, 43'h4,
               120'h40_0000_0000_0000_0000_0000_0000_0000};
    for (int i = 6; i < 12; i++) begin
      tbl[i].a = rnd60();
      tbl[i].b = rnd60();
      tbl[i].q = 43'(rnd60());
      tbl[i].c = ref_mul(tbl[i].a, tbl[i].b);
    end

    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      iv[s] = 1'b0; a[s] = '0; b[s] = '0; qi[s] = '0;
    end
    #1;
    check("reset in_ready", ir[0], 0);
    check("reset out_valid", ov[0], 0);
    check("reset C", c[0], 0);
    check("reset qH", qo[0], 0);
    check("reset in_ready dw60", ir[1], 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("idle in_ready", ir[0], 1);
    @(negedge clk);

    for (int i = 0; i < 12; i++)
      run_op(0, tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].c, 3, $sformatf("vec%0d", i));

    qi[0] = 43'h55;
    run_two(0, 60'd7, 60'd9, 60'h800_0000_0000_0000, 60'd4,
            acc0, acc1, pul0, pul1, pc0, pc1, nacc, npul, stable);
    check("stream accepts", nacc, 2);
    check("stream accept0", acc0, 0);
    check("stream accept1", acc1, 4);
    check("stream pulses", npul, 2);
    check("stream pulse0", pul0, 3);
    check("stream pulse1", pul1, 7);
    check("stream C0", pc0, 63);
    check("stream C1", pc1, 120'h2000_0000_0000_0000);
    check("stream C stable", stable, 1);

    run_two(0, 60'd10, 60'd10, 60'd1, 60'd1,
            acc0, acc1, pul0, pul1, pc0, pc1, nacc, npul, stable);
    check("busy accept1", acc1, 4);
    check("busy pulse0", pul0, 3);
    check("busy C0", pc0, 100);
    check("busy pulse1", pul1, 7);
    check("busy C1", pc1, 1);

    iv[0] = 1'b1; a[0] = 60'd5; b[0] = 60'd7; qi[0] = 43'h99;
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst in_ready", ir[0], 0);
    check("midrst out_valid", ov[0], 0);
    check("midrst C", c[0], 0);
    check("midrst qH", qo[0], 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("postrst in_ready", ir[0], 1);
    seen = 0;
    for (int e = 0; e < 8; e++) begin
      @(negedge clk);
      if (ov[0]) seen++;
    end
    check("postrst no pulse", seen, 0);
    check("postrst C", c[0], 0);

    run_op(1, 60'h800_0000_0000_0000, 60'd2, 43'h1, 120'h1000_0000_0000_0000, 1, "dw60 basic");
    for (int i = 0; i < 3; i++)
      run_op(1, tbl[6+i].a, tbl[6+i].b, tbl[6+i].q, tbl[6+i].c, 1, $sformatf("dw60 vec%0d", i));
    run_op(1, tbl[1].a, tbl[1].b, tbl[1].q, tbl[1].c, 1, "dw60 max");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
